// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier for signed operands.
// One add/sub step per clock over an n+1 bit accumulator.

module adder_subtractor_nbit #(
  parameter int n = 5
) (
  input  logic [n-1:0] x,
  input  logic [n-1:0] y,
  input  logic         add_n,
  output logic [n-1:0] sum,
  output logic         cout
);

  logic [n-1:0] y_eff;

  // Subtract as x + ~y + 1, with add_n doubling as the carry-in.
  assign y_eff       = y ^ {n{add_n}};
  assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{n{1'b0}}, add_n};

endmodule

module booth_multiplier_seq #(
  parameter int n = 4
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
  input  logic [n-1:0]   multiplicand,
  input  logic [n-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*n-1:0] product
);

  localparam int CW = $clog2(n + 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t         state, state_d;
  logic [n:0]     a, a_d, m, m_d;
  logic [n-1:0]   q, q_d;
  logic           qm1, qm1_d;
  logic [CW-1:0]  cnt, cnt_d;
  logic           done_d;
  logic [2*n-1:0] prod_d;

  logic [n:0]     sum, a_nxt, a_sh;
  logic [n-1:0]   q_sh;
  logic           sub;
  logic           add_cout_unused;

  assign sub  = q[0] & ~qm1;
  assign busy = (state == BUSY);

  adder_subtractor_nbit #(.n(n + 1)) u_addsub (
    .x     (a),
    .y     (m),
    .add_n (sub),
    .sum   (sum),
    .cout  (add_cout_unused)
  );

  // Pair 01 adds M, 10 subtracts it; 00/11 keep A as is.
  always_comb begin
    a_nxt = (q[0] ^ qm1) ? sum : a;
    a_sh  = {a_nxt[n], a_nxt[n:1]};
    q_sh  = {a_nxt[0], q[n-1:1]};
  end

  always_comb begin
    state_d = state;
    a_d     = a;
    m_d     = m;
    q_d     = q;
    qm1_d   = qm1;
    cnt_d   = cnt;
    done_d  = 1'b0;
    prod_d  = product;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_d = BUSY;
          m_d     = {multiplicand[n-1], multiplicand};
          q_d     = multiplier;
          a_d     = '0;
          qm1_d   = 1'b0;
          cnt_d   = CW'(n);
        end
      end
      BUSY: begin
        a_d   = a_sh;
        q_d   = q_sh;
        qm1_d = q[0];
        cnt_d = cnt - 1'b1;
        if (cnt == CW'(1)) begin
          prod_d  = {a_sh[n-1:0], q_sh};
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      a       <= '0;
      m       <= '0;
      q       <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      done    <= 1'b0;
      product <= '0;
    end else begin
      state   <= state_d;
      a       <= a_d;
      m       <= m_d;
      q       <= q_d;
      qm1     <= qm1_d;
      cnt     <= cnt_d;
      done    <= done_d;
      product <= prod_d;
    end
  end

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Bench for booth_multiplier_seq: vector table, corner sequences,
// exhaustive n=4 and random n=8 against plain signed multiplication.

module tb_booth_multiplier_seq;

  logic        clk = 1'b0;
  logic        reset_n;

  logic        start4;
  logic [3:0]  mc4, mq4;
  logic        busy4, done4;
  logic [7:0]  prod4;

  logic        start8;
  logic [7:0]  mc8, mq8;
  logic        busy8, done8;
  logic [15:0] prod8;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  booth_multiplier_seq #(.n(4)) dut4 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start4),
    .multiplicand (mc4),
    .multiplier   (mq4),
    .busy         (busy4),
    .done         (done4),
    .product      (prod4)
  );

  booth_multiplier_seq #(.n(8)) dut8 (
    .clk          (clk),
    .reset_n      (reset_n),
    .start        (start8),
    .multiplicand (mc8),
    .multiplier   (mq8),
    .busy         (busy8),
    .done         (done8),
    .product      (prod8)
  );

  typedef struct {
    logic [3:0] m;
    logic [3:0] q;
    logic [7:0] p;
  } vec_t;

  vec_t tbl[5];

  task automatic check(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [7:0] ref4(input logic [3:0] m,
                                      input logic [3:0] q);
    return 8'(int'($signed(m)) * int'($signed(q)));
  endfunction

  function automatic logic [15:0] ref8(input logic [7:0] m,
                                       input logic [7:0] q);
    return 16'(int'($signed(m)) * int'($signed(q)));
  endfunction

  // Called at a negedge with the unit idle (or in its done cycle).
  task automatic mul4(input logic [3:0] m, input logic [3:0] q,
                      input logic [7:0] exp, input bit hold);
    logic [7:0] prev;
    int cyc;
    prev   = prod4;
    start4 = 1'b1;
    mc4    = m;
    mq4    = q;
    @(negedge clk);
    if (!hold) start4 = 1'b0;
    mc4 = 4'($urandom);
    mq4 = 4'($urandom);
    check("busy_e0", 64'(busy4), 64'(1));
    check("done_e0", 64'(done4), 64'(0));
    check("prod_held", 64'(prod4), 64'(prev));
    cyc = 1;
    while (!done4 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check("latency4", 64'(cyc), 64'(5));
    check("busy_at_done", 64'(busy4), 64'(0));
    check("prod4", 64'(prod4), 64'(exp));
  endtask

  task automatic mul8(input logic [7:0] m, input logic [7:0] q);
    logic [15:0] prev;
    int cyc;
    prev   = prod8;
    start8 = 1'b1;
    mc8    = m;
    mq8    = q;
    @(negedge clk);
    start8 = 1'b0;
    mc8    = 8'($urandom);
    mq8    = 8'($urandom);
    check("busy8_e0", 64'(busy8), 64'(1));
    check("prod8_held", 64'(prod8), 64'(prev));
    cyc = 1;
    while (!done8 && cyc < 30) begin
      @(negedge clk);
      cyc++;
    end
    check("latency8", 64'(cyc), 64'(9));
    check("prod8", 64'(prod8), 64'(ref8(m, q)));
  endtask

  initial begin
    tbl[0] = '{4'd3, 4'd5, 8'h0F};
    tbl[1] = '{4'h8, 4'h8, 8'h40};
    tbl[2] = '{4'd7, 4'h8, 8'hC8};
    tbl[3] = '{4'd0, 4'hD, 8'h00};
    tbl[4] = '{4'hF, 4'hF, 8'h01};

    reset_n = 1'b0;
    start4  = 1'b0;
    mc4     = '0;
    mq4     = '0;
    start8  = 1'b0;
    mc8     = '0;
    mq8     = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 64'(busy4), 64'(0));
    check("rst_done", 64'(done4), 64'(0));
    check("rst_prod", 64'(prod4), 64'(0));
    check("rst_prod8", 64'(prod8), 64'(0));
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      mul4(tbl[i].m, tbl[i].q, tbl[i].p, 1'b0);
      @(negedge clk);
      check("done_one_cycle", 64'(done4), 64'(0));
      check("prod_hold_idle", 64'(prod4), 64'(tbl[i].p));
    end

    // Asynchronous reset two cycles into an operation.
    start4 = 1'b1;
    mc4    = 4'd5;
    mq4    = 4'd3;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy4), 64'(0));
    check("abort_done", 64'(done4), 64'(0));
    check("abort_prod", 64'(prod4), 64'(0));
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("abort_no_done", 64'(done4), 64'(0));
      if (i == 1) reset_n = 1'b1;
    end
    mul4(4'd2, 4'hD, 8'hFA, 1'b0);
    @(negedge clk);

    // start held high: back-to-back every 5 cycles, all 256 pairs.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] iv;
      iv = 8'(i);
      mul4(iv[7:4], iv[3:0], ref4(iv[7:4], iv[3:0]), 1'b1);
    end
    start4 = 1'b0;
    @(negedge clk);
    check("after_b2b_done", 64'(done4), 64'(0));
    check("after_b2b_busy", 64'(busy4), 64'(0));

    mul8(8'h80, 8'h80);
    mul8(8'h7F, 8'h80);
    mul8(8'hFF, 8'h01);
    for (int i = 0; i < 40; i++) mul8(8'($urandom), 8'($urandom));

    @(negedge clk);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/booth_multiplier_seq.md
Name: booth_multiplier_seq

Overview:
- Sequential radix-2 Booth multiplier for signed two's-complement operands.
- Drives one adder_subtractor_nbit instance as its datapath, issuing add or subtract on each iteration from the Booth bit pair. The instance is width n+1.
- Consumes one addition/subtraction result per clock and produces a 2n-bit signed product after n iterations.
- Sits between the operand source (register file/control) and the result writeback.

Parameters:
n  4  operand width in bits; product is 2n bits; n >= 2

Ports:
clk  input  1  system clock, all state changes on rising edge
reset_n  input  1  asynchronous active-low reset
start  input  1  request to begin a multiply; sampled only in IDLE
multiplicand  input  n  signed operand M; captured on accepted start
multiplier  input  n  signed operand Q; captured on accepted start
busy  output  1  high while iterations are in progress
done  output  1  one-cycle pulse: product has just been updated
product  output  2n  signed result register; holds value until next completion

Behaviour:
- Reset (reset_n=0, asynchronous):
  - state=IDLE; A, Q, q_m1, M, count all cleared.
  - busy=0, done=0, product=0.
  - Takes effect immediately, including mid-operation. The aborted operation produces no done and does not modify product.
- Registers:
  - A: n+1 bits (accumulator).
  - Q: n bits.
  - q_m1: 1 bit.
  - M: n+1 bits, sign-extended multiplicand.
  - count: ceil(log2(n+1)) bits.
- Datapath: adder_subtractor_nbit #(.n(n+1)) with x=A, y=M, add_n=1 when {Q[0],q_m1}=2'b10, else 0. Sum/cout of n+1 bits; cout unused. The n+1 width guarantees A never overflows, including M = -2^(n-1).
- Step value:
  - A_next = sum if {Q[0],q_m1} is 01 or 10, else A.
  - Then arithmetic shift right of {A_next,Q,q_m1} by 1; the MSB of A_next is replicated.
- FSM states: IDLE, BUSY.
  - IDLE, start=1 at edge E0:
    - Load M = sign-extend(multiplicand), Q = multiplier, A = 0, q_m1 = 0, count = n.
    - Go to BUSY; busy=1 from E0.
    - done is cleared at E0 if it was set.
  - IDLE, start=0: hold; done cleared to 0 at the next edge.
  - BUSY: each edge performs one Booth step and decrements count.
    - At the edge where count goes 1->0 (edge E0+n), product <= {A_shifted[n-1:0], Q_shifted}.
    - At that same edge: done <= 1, busy <= 0, state <= IDLE.
- Latency: start sampled at E0; product valid and done=1 in the cycle after E0+n. Back-to-back throughput is one multiply per n+1 cycles.
- start while BUSY is ignored, and operand inputs are ignored. In-flight operands are unaffected by input changes after E0.
- start=1 during the done cycle (state IDLE) is accepted. done drops and busy rises at the same edge, and product holds its previous value until the new completion.
- product is never modified except at completion or reset. done is never high for two consecutive cycles from a single operation.
- Result range: full signed 2n-bit product with no saturation. (-2^(n-1))^2 = 2^(2n-2) is representable.

Test Plan:
- n=4, reset then M=3, Q=5, start pulse -> busy high 4 cycles; done pulse in cycle after E0+4; product=8'h0F (15).
- n=4, M=-8 (4'h8), Q=-8 -> product=8'h40 (64). Checks the most-negative multiplicand and the n+1-bit accumulator.
- n=4, M=7, Q=-8 -> product=8'hC8 (-56). Then M=0, Q=-3 -> product=8'h00. Previous value held until the second done.
- n=4, start held high continuously with changing operands -> operands accepted only in IDLE/done cycles. The next multiply starts at the done edge, giving period 5 cycles. Inputs changed mid-operation have no effect.
- n=4, assert reset_n=0 asynchronously two cycles into an operation (off clock edge) -> busy/done/product drop to 0 immediately, with no done. After release, a new start of 2*-3 gives product=8'hFA (-6).
- n=4 exhaustive: all 256 signed (M,Q) pairs, back-to-back -> each product equals signed M*Q; exactly one done per accepted start. Repeat random pairs at n=8.
